// File: rtl/adc_uart_tx.sv
// adc_uart_tx: serialises 12-bit ADC samples (plus OTR flag) as two UART bytes
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-low reset
//   ADC_BIT      12-bit sample, latched with ADC_OTR on accept
//   ADC_OTR      out-of-range flag, carried in the header byte
//   SAMPLE_VALID source has a sample to send
//   SAMPLE_READY block is idle and will accept a sample this cycle
//   UART_TX      registered serial line, idle high
//   BUSY         a frame is in flight (always ~SAMPLE_READY)
// Optional feature: define ADC_UART_TX_PARITY_EN for an even-parity bit per byte.
module adc_uart_tx #(
    parameter int BAUD_DIV = 50
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] ADC_BIT,
    input  logic        ADC_OTR,
    input  logic        SAMPLE_VALID,
    output logic        SAMPLE_READY,
    output logic        UART_TX,
    output logic        BUSY
);
    localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ADC_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t      state, state_n;
    logic [15:0] baud_cnt, baud_n;
    logic [2:0]  bit_cnt, bit_n;
    logic        byte_idx, idx_n;
    logic [12:0] sample, sample_n;
    logic        tx, tx_n;
    logic [7:0]  cur_byte;
    logic        tick;
    // Header byte has bit 7 set so a receiver can find sample boundaries.
    assign cur_byte = byte_idx ? {2'b00, sample[5:0]} : {1'b1, sample[12:6]};
    assign tick = baud_cnt == 16'd0;
    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt;
        idx_n    = byte_idx;
        sample_n = sample;
        tx_n     = tx;
        baud_n   = (state == IDLE) ? baud_cnt : tick ? RELOAD : baud_cnt - 16'd1;
        case (state)
            IDLE: if (SAMPLE_VALID) begin
                sample_n = {ADC_OTR, ADC_BIT};
                idx_n    = 1'b0;
                bit_n    = 3'd0;
                baud_n   = RELOAD;
                tx_n     = 1'b0;
                state_n  = START;
            end
            START: if (tick) begin
                state_n = DATA;
                bit_n   = 3'd0;
                tx_n    = cur_byte[0];
            end
            DATA: if (tick) begin
                if (bit_cnt == 3'd7) begin
`ifdef ADC_UART_TX_PARITY_EN
                    state_n = PARITY;
                    tx_n    = ^cur_byte;
`else
                    state_n = STOP;
                    tx_n    = 1'b1;
`endif
                end else begin
                    bit_n = bit_cnt + 3'd1;
                    tx_n  = cur_byte[bit_n];
                end
            end
`ifdef ADC_UART_TX_PARITY_EN
            PARITY: if (tick) begin
                state_n = STOP;
                tx_n    = 1'b1;
            end
`endif
            STOP: if (tick) begin
                if (!byte_idx) begin
                    idx_n   = 1'b1;
                    state_n = START;
                    tx_n    = 1'b0;
                end else begin
                    idx_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            byte_idx <= 1'b0;
            sample   <= 13'd0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            byte_idx <= idx_n;
            sample   <= sample_n;
            tx       <= tx_n;
        end
    end
    assign UART_TX      = tx;
    assign BUSY         = state != IDLE;
    assign SAMPLE_READY = state == IDLE;
endmodule

// File: tb/tb_adc_uart_tx.sv
// tb_adc_uart_tx: checks adc_uart_tx at BAUD_DIV=50 and BAUD_DIV=2 against a bit-list model
module tb_adc_uart_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] adc_a = '0, adc_b = '0;
    logic        otr_a = 1'b0, otr_b = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        ready_a, ready_b, tx_a, tx_b, busy_a, busy_b;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    adc_uart_tx #(.BAUD_DIV(50)) u_a (
        .CLK(clk), .RST(rst_n), .ADC_BIT(adc_a), .ADC_OTR(otr_a),
        .SAMPLE_VALID(valid_a), .SAMPLE_READY(ready_a), .UART_TX(tx_a), .BUSY(busy_a)
    );
    adc_uart_tx #(.BAUD_DIV(2)) u_b (
        .CLK(clk), .RST(rst_n), .ADC_BIT(adc_b), .ADC_OTR(otr_b),
        .SAMPLE_VALID(valid_b), .SAMPLE_READY(ready_b), .UART_TX(tx_b), .BUSY(busy_b)
    );

    typedef struct {
        int         w;
        logic [11:0] adc;
        logic        otr;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    function automatic logic txo(input int w);
        return w != 0 ? tx_b : tx_a;
    endfunction
    function automatic logic busyo(input int w);
        return w != 0 ? busy_b : busy_a;
    endfunction
    function automatic logic readyo(input int w);
        return w != 0 ? ready_b : ready_a;
    endfunction

    // Reference: header byte = 128 + 64*otr + (adc / 64), data byte = adc mod 64.
    function automatic logic [15:0] model_bytes(input logic [11:0] adc, input logic otr);
        int h, l;
        h = 128 + (otr ? 64 : 0) + int'(adc) / 64;
        l = int'(adc) % 64;
        return {8'(h), 8'(l)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int w, input logic v, input logic [11:0] a, input logic o);
        if (w != 0) begin valid_b = v; adc_b = a; otr_b = o; end
        else begin valid_a = v; adc_a = a; otr_a = o; end
    endtask

    // Called one step after the accept edge; walks every bit cycle then checks the idle cycle.
    task automatic run_frame(input int w, input logic [7:0] b0, input logic [7:0] b1, input string tag);
        int   div;
        int   n;
        int   errs;
        logic bits [24];
        logic [7:0] b;
        div = (w != 0) ? 2 : 50;
        n = 0;
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? b0 : b1;
            bits[n] = 1'b0; n = n + 1;
            for (int i = 0; i < 8; i++) begin bits[n] = b[i]; n = n + 1; end
`ifdef ADC_UART_TX_PARITY_EN
            bits[n] = ^b; n = n + 1;
`endif
            bits[n] = 1'b1; n = n + 1;
        end
        for (int j = 0; j < n; j++) begin
            errs = 0;
            for (int c = 0; c < div; c++) begin
                if (txo(w) !== bits[j] || busyo(w) !== 1'b1) errs++;
                @(posedge clk); #1;
            end
            chk($sformatf("%s bit%0d bad_cycles", tag, j), errs, 0);
        end
        chk($sformatf("%s idle busy", tag), int'(busyo(w)), 0);
        chk($sformatf("%s idle tx", tag), int'(txo(w)), 1);
        chk($sformatf("%s idle ready", tag), int'(readyo(w)), 1);
    endtask

    task automatic offer(input int w, input logic [11:0] a, input logic o);
        set_in(w, 1'b1, a, o);
        chk("ready before accept", int'(readyo(w)), 1);
        @(posedge clk); #1;
        set_in(w, 1'b0, 12'h000, 1'b0);
    endtask

    vec_t vecs [6];
    logic [15:0] mb;
    logic [11:0] ra;
    logic        ro;
    int          idle_errs;

    initial begin
        vecs[0] = '{0, 12'h7E3, 1'b0, 8'h9F, 8'h23};
        vecs[1] = '{0, 12'h7E3, 1'b1, 8'hDF, 8'h23};
        vecs[2] = '{1, 12'hFFF, 1'b0, 8'hBF, 8'h3F};
        vecs[3] = '{1, 12'h001, 1'b0, 8'h80, 8'h01};
        vecs[4] = '{1, 12'h000, 1'b1, 8'hC0, 8'h00};
        vecs[5] = '{1, 12'h555, 1'b1, 8'hD5, 8'h15};

        repeat (3) @(posedge clk);
        #1;
        chk("reset tx_a", int'(tx_a), 1);
        chk("reset busy_a", int'(busy_a), 0);
        chk("reset ready_a", int'(ready_a), 1);
        chk("reset tx_b", int'(tx_b), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            offer(vecs[i].w, vecs[i].adc, vecs[i].otr);
            run_frame(vecs[i].w, vecs[i].b0, vecs[i].b1, $sformatf("vec%0d", i));
            @(posedge clk); #1;
        end

        // Valid held high; input changes mid-frame, second sample taken after one idle cycle.
        set_in(0, 1'b1, 12'h7E3, 1'b0);
        @(posedge clk); #1;
        fork
            begin
                repeat (300) @(posedge clk);
                #2 adc_a = 12'h001;
            end
        join_none
        run_frame(0, 8'h9F, 8'h23, "hold first");
        @(posedge clk); #1;
        set_in(0, 1'b0, 12'h000, 1'b0);
        run_frame(0, 8'h80, 8'h01, "hold second");

        // Reset during byte0 data bit 3 aborts the frame.
        offer(0, 12'h7E3, 1'b0);
        repeat (225) @(posedge clk);
        #1;
        chk("abort busy before reset", int'(busy_a), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort tx at reset", int'(tx_a), 1);
        chk("abort ready at reset", int'(ready_a), 1);
        chk("abort busy at reset", int'(busy_a), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle_errs = 0;
        for (int c = 0; c < 1100; c++) begin
            @(posedge clk); #1;
            if (tx_a !== 1'b1 || busy_a !== 1'b0) idle_errs++;
        end
        chk("post-abort idle bad_cycles", idle_errs, 0);

        // Accept on the very first edge after reset release.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        offer(1, 12'hFFF, 1'b0);
        run_frame(1, 8'hBF, 8'h3F, "first edge after reset");

        // Random samples against the model, with random idle gaps.
        for (int i = 0; i < 25; i++) begin
            ra = 12'($urandom_range(0, 4095));
            ro = 1'($urandom_range(0, 1));
            mb = model_bytes(ra, ro);
            offer(1, ra, ro);
            run_frame(1, mb[15:8], mb[7:0], $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
